// File: rtl/mode_countdown_timer.sv
// Loads the hh:mm:ss duration of the selected mode on start and counts it down once per TICK_DIV cycles.
// Status is registered; rem_bcd is decoded combinationally from the remaining time.
module mode_countdown_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int PS_W     = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode_sel,
  input  logic        start,
  input  logic        pause_toggle,
  input  logic        abort,
  input  logic [4:0]  cfg1_hour,
  input  logic [5:0]  cfg1_min,
  input  logic [5:0]  cfg1_sec,
  input  logic [4:0]  cfg2_hour,
  input  logic [5:0]  cfg2_min,
  input  logic [5:0]  cfg2_sec,
  input  logic [4:0]  cfg3_hour,
  input  logic [5:0]  cfg3_min,
  input  logic [5:0]  cfg3_sec,
  output logic        busy,
  output logic        paused,
  output logic        done,
  output logic [4:0]  rem_hour,
  output logic [5:0]  rem_min,
  output logic [5:0]  rem_sec,
  output logic [23:0] rem_bcd
);

  // state | meaning
  // IDLE  | waiting for start with a mode selected
  // LOAD  | duration captured, prescaler cleared (1 cycle)
  // RUN   | prescaler running, rem decremented on each wrap
  // PAUSE | prescaler and rem frozen
  // DONE  | natural expiry, done pulse (1 cycle)
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t          state, state_nx;
  logic [PS_W-1:0] prescaler;
  logic            tick, rem_zero, rem_last, do_load;
  logic [4:0]      sel_h, cap_h, dec_h;
  logic [5:0]      sel_m, sel_s, cap_m, cap_s, dec_m, dec_s;

  assign tick     = (state == S_RUN) && (prescaler == PS_W'(TICK_DIV - 1));
  assign rem_zero = (rem_hour == 5'd0) && (rem_min == 6'd0) && (rem_sec == 6'd0);
  assign rem_last = (rem_hour == 5'd0) && (rem_min == 6'd0) && (rem_sec == 6'd1);
  assign do_load  = (state == S_IDLE) && (state_nx == S_LOAD);

  always_comb begin
    sel_h = 5'd0;
    sel_m = 6'd0;
    sel_s = 6'd0;
    case (mode_sel)
      2'b01:   begin sel_h = cfg1_hour; sel_m = cfg1_min; sel_s = cfg1_sec; end
      2'b10:   begin sel_h = cfg2_hour; sel_m = cfg2_min; sel_s = cfg2_sec; end
      2'b11:   begin sel_h = cfg3_hour; sel_m = cfg3_min; sel_s = cfg3_sec; end
      default: ;
    endcase
    cap_h = (sel_h > 5'd23) ? 5'd23 : sel_h;
    cap_m = (sel_m > 6'd59) ? 6'd59 : sel_m;
    cap_s = (sel_s > 6'd59) ? 6'd59 : sel_s;
  end

  // Borrow chain; RUN is never entered with 0:0:0 so the hour borrow cannot underflow.
  always_comb begin
    dec_h = rem_hour;
    dec_m = rem_min;
    dec_s = rem_sec;
    if (rem_sec != 6'd0) begin
      dec_s = rem_sec - 6'd1;
    end else if (rem_min != 6'd0) begin
      dec_m = rem_min - 6'd1;
      dec_s = 6'd59;
    end else begin
      dec_h = rem_hour - 5'd1;
      dec_m = 6'd59;
      dec_s = 6'd59;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && (mode_sel != 2'b00)) state_nx = S_LOAD;
      S_LOAD:  if (abort) state_nx = S_IDLE;
               else if (rem_zero) state_nx = S_DONE;
               else state_nx = S_RUN;
      S_RUN:   if (abort) state_nx = S_IDLE;
               else if (pause_toggle) state_nx = S_PAUSE;
               else if (tick && rem_last) state_nx = S_DONE;
      S_PAUSE: if (abort) state_nx = S_IDLE;
               else if (pause_toggle) state_nx = S_RUN;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      prescaler <= '0;
      rem_hour  <= 5'd0;
      rem_min   <= 6'd0;
      rem_sec   <= 6'd0;
      busy      <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= state_nx;
      busy   <= (state_nx == S_LOAD) || (state_nx == S_RUN) || (state_nx == S_PAUSE);
      paused <= (state_nx == S_PAUSE);
      done   <= (state_nx == S_DONE);
      if (do_load) begin
        rem_hour <= cap_h;
        rem_min  <= cap_m;
        rem_sec  <= cap_s;
      end else if (abort && ((state == S_LOAD) || (state == S_RUN) || (state == S_PAUSE))) begin
        prescaler <= '0;
        rem_hour  <= 5'd0;
        rem_min   <= 6'd0;
        rem_sec   <= 6'd0;
      end else if (state == S_LOAD) begin
        prescaler <= '0;
      end else if ((state == S_RUN) && !pause_toggle) begin
        if (tick) begin
          prescaler <= '0;
          rem_hour  <= dec_h;
          rem_min   <= dec_m;
          rem_sec   <= dec_s;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

  assign rem_bcd = {4'(rem_hour / 5'd10), 4'(rem_hour % 5'd10),
                    4'(rem_min / 6'd10),  4'(rem_min % 6'd10),
                    4'(rem_sec / 6'd10),  4'(rem_sec % 6'd10)};

endmodule

// File: tb/tb_mode_countdown_timer.sv
// Bench for mode_countdown_timer with TICK_DIV=4: directed scenarios plus random strobes,
// checked against an elapsed-run-time model (remaining = total - elapsed/TICK_DIV).
module tb_mode_countdown_timer;
  localparam int TD = 4;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, pause_toggle = 1'b0, abort = 1'b0;
  logic [1:0]  mode_sel = 2'b00;
  logic [4:0]  cfg_h [1:3];
  logic [5:0]  cfg_m [1:3];
  logic [5:0]  cfg_s [1:3];
  logic        busy, paused, done;
  logic [4:0]  rem_hour;
  logic [5:0]  rem_min, rem_sec;
  logic [23:0] rem_bcd;
  logic [43:0] dut_vec;

  int checks = 0, errors = 0;
  int m_st, m_total, m_elapsed;   // m_st: 0 idle, 1 load, 2 run, 3 pause, 4 done

  always #5 clk = ~clk;

  mode_countdown_timer #(.TICK_DIV(TD), .PS_W(3)) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .start(start),
    .pause_toggle(pause_toggle), .abort(abort),
    .cfg1_hour(cfg_h[1]), .cfg1_min(cfg_m[1]), .cfg1_sec(cfg_s[1]),
    .cfg2_hour(cfg_h[2]), .cfg2_min(cfg_m[2]), .cfg2_sec(cfg_s[2]),
    .cfg3_hour(cfg_h[3]), .cfg3_min(cfg_m[3]), .cfg3_sec(cfg_s[3]),
    .busy(busy), .paused(paused), .done(done),
    .rem_hour(rem_hour), .rem_min(rem_min), .rem_sec(rem_sec), .rem_bcd(rem_bcd)
  );

  assign dut_vec = {busy, paused, done, rem_hour, rem_min, rem_sec, rem_bcd};

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [43:0] exp_vec();
    int r, h, m, s;
    r = m_total - m_elapsed / TD;
    h = r / 3600;
    m = (r / 60) % 60;
    s = r % 60;
    return {(m_st >= 1 && m_st <= 3), (m_st == 3), (m_st == 4),
            5'(h), 6'(m), 6'(s), bcd2(h), bcd2(m), bcd2(s)};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_st = 0; m_total = 0; m_elapsed = 0;
    end else begin
      case (m_st)
        0: if (start && mode_sel != 2'b00) begin
             m_total = clampv(int'(cfg_h[mode_sel]), 23) * 3600 +
                       clampv(int'(cfg_m[mode_sel]), 59) * 60 +
                       clampv(int'(cfg_s[mode_sel]), 59);
             m_elapsed = 0;
             m_st = 1;
           end
        1: if (abort) begin m_st = 0; m_total = 0; m_elapsed = 0; end
           else m_st = (m_total == 0) ? 4 : 2;
        2: if (abort) begin m_st = 0; m_total = 0; m_elapsed = 0; end
           else if (pause_toggle) m_st = 3;
           else begin
             m_elapsed++;
             if (m_total - m_elapsed / TD == 0) m_st = 4;
           end
        3: if (abort) begin m_st = 0; m_total = 0; m_elapsed = 0; end
           else if (pause_toggle) m_st = 2;
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_cfg(input int md, input int h, input int m, input int s);
    cfg_h[md] = 5'(h); cfg_m[md] = 6'(m); cfg_s[md] = 6'(s);
  endtask

  task automatic pulse_start(input logic [1:0] md);
    mode_sel = md; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if (dut_vec !== 44'd0) begin errors++; $display("FAIL reset_state: got %h expected 0", dut_vec); end
    rst = 1'b0;
    set_cfg(1, 0, 0, 9);
    pulse_start(2'b01);
    repeat (8) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_prerun: got %h expected %h", dut_vec, exp_vec()); end
    end
    rst = 1'b1;
    repeat (2) begin
      step();
      checks++;
      if (dut_vec !== 44'd0) begin errors++; $display("FAIL reset_midrun: got %h expected 0", dut_vec); end
    end
    rst = 1'b0;
    step();
    checks++;
    if (dut_vec !== 44'd0) begin errors++; $display("FAIL reset_after: got %h expected 0", dut_vec); end
  endtask

  task automatic test_countdown();
    int done_cnt = 0, done_at = -1;
    set_cfg(1, 0, 0, 3);
    pulse_start(2'b01);
    for (int n = 0; n <= 20; n++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL countdown n=%0d: got %h expected %h", n, dut_vec, exp_vec()); end
      if (n == 5 || n == 9) begin
        checks++;
        if (rem_sec !== 6'((n == 5) ? 2 : 1)) begin errors++; $display("FAIL countdown_sec n=%0d: got %0d", n, rem_sec); end
      end
      if (done) begin done_cnt++; done_at = n; end
      step();
    end
    checks++;
    if (done_cnt != 1 || done_at != 13) begin
      errors++; $display("FAIL countdown_done: got count %0d at %0d expected 1 at 13", done_cnt, done_at);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL countdown_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_rollover();
    set_cfg(2, 1, 0, 0);
    pulse_start(2'b10);
    repeat (4) step();
    checks++;
    if (rem_bcd !== 24'h010000) begin errors++; $display("FAIL rollover_pre: got %h expected 010000", rem_bcd); end
    step();
    checks++;
    if (rem_bcd !== 24'h005959 || {rem_hour, rem_min, rem_sec} !== {5'd0, 6'd59, 6'd59}) begin
      errors++; $display("FAIL rollover: got %h %0d:%0d:%0d expected 005959", rem_bcd, rem_hour, rem_min, rem_sec);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (dut_vec !== 44'd0) begin errors++; $display("FAIL rollover_abort: got %h expected 0", dut_vec); end
  endtask

  task automatic test_pause();
    int n = 0, done_at = -1;
    set_cfg(3, 0, 0, 5);
    pulse_start(2'b11);
    repeat (6) begin step(); n++; end
    pause_toggle = 1'b1;
    step(); n++;
    pause_toggle = 1'b0;
    repeat (20) begin
      step(); n++;
      checks++;
      if (rem_sec !== 6'd4 || paused !== 1'b1 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL pause_hold n=%0d: got %h expected %h", n, dut_vec, exp_vec());
      end
    end
    pause_toggle = 1'b1;
    step(); n++;
    pause_toggle = 1'b0;
    while (n < 80 && done_at < 0) begin
      step(); n++;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL pause_resume n=%0d: got %h expected %h", n, dut_vec, exp_vec()); end
      if (done) done_at = n;
    end
    checks++;
    if (done_at != 43) begin errors++; $display("FAIL pause_total: done at %0d expected 43", done_at); end
    step();
  endtask

  task automatic test_abort();
    set_cfg(1, 0, 0, 9);
    pulse_start(2'b01);
    repeat (7) step();
    abort = 1'b1; pause_toggle = 1'b1;
    step();
    abort = 1'b0; pause_toggle = 1'b0;
    checks++;
    if (dut_vec !== 44'd0) begin errors++; $display("FAIL abort_pause: got %h expected 0", dut_vec); end
    repeat (10) begin
      step();
      checks++;
      if (done !== 1'b0 || dut_vec !== exp_vec()) begin errors++; $display("FAIL abort_quiet: got %h expected %h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_edges();
    set_cfg(1, 0, 0, 0);
    pulse_start(2'b01);
    checks++;
    if ({busy, done} !== 2'b10 || rem_bcd !== 24'h0) begin errors++; $display("FAIL zero_load: got %h", dut_vec); end
    step();
    checks++;
    if ({busy, paused, done} !== 3'b001) begin errors++; $display("FAIL zero_done: got %b expected 001", {busy, paused, done}); end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL zero_idle: got %b expected 00", {busy, done}); end
    set_cfg(1, 31, 60, 63);
    pulse_start(2'b01);
    set_cfg(1, 0, 0, 2);
    checks++;
    if (rem_bcd !== 24'h235959 || {rem_hour, rem_min, rem_sec} !== {5'd23, 6'd59, 6'd59}) begin
      errors++; $display("FAIL clamp: got %h expected 235959", rem_bcd);
    end
    step();
    checks++;
    if (rem_bcd !== 24'h235959) begin errors++; $display("FAIL cfg_ignored: got %h expected 235959", rem_bcd); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    pulse_start(2'b00);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mode_none: busy %b expected 0", busy); end
    pause_toggle = 1'b1;
    step();
    pause_toggle = 1'b0;
    checks++;
    if (dut_vec !== 44'd0) begin errors++; $display("FAIL pause_idle: got %h expected 0", dut_vec); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          int md = $urandom_range(1, 3);
          if ($urandom_range(0, 3) != 0) set_cfg(md, 0, $urandom_range(0, 1), $urandom_range(0, 6));
          else set_cfg(md, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
        end
        mode_sel     = 2'($urandom_range(0, 3));
        start        = ($urandom_range(0, 9) == 0);
        pause_toggle = ($urandom_range(0, 14) == 0);
        abort        = ($urandom_range(0, 49) == 0);
        step();
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL random it=%0d c=%0d: got %h expected %h", it, c, dut_vec, exp_vec());
        end
      end
    end
    start = 1'b0; pause_toggle = 1'b0; abort = 1'b0;
  endtask

  initial begin
    for (int i = 1; i <= 3; i++) set_cfg(i, 0, 0, 0);
    m_st = 0; m_total = 0; m_elapsed = 0;
    test_reset();
    test_countdown();
    test_rollover();
    test_pause();
    test_abort();
    test_edges();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
